// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle multiply/divide sequencer for the E stage.
// Owns HI/LO. MULT/MULTU/DIV/DIVU compute their result at accept and park it
// in pend_hi/pend_lo. The result commits to HI/LO when the busy counter
// expires. MTHI/MTLO write HI/LO directly at accept.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   start, md_op      E-stage md op valid + opcode (110/111 reserved)
//   src_a, src_b      forwarded rs / rt
//   d_md_use          D-stage instruction touches the md unit
//   busy              op in flight
//   stall             D-stage stall request (combinational)
//   hi, lo            HI/LO registers
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [2:0] {
    OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2,
    OP_DIVU = 3'd3, OP_MTHI  = 3'd4, OP_MTLO = 3'd5
  } md_op_t;

  localparam logic [7:0] MULT_CNT = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_CNT  = 8'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  // Arithmetic datapath. The low 64 bits of a product of sign-extended
  // operands is the signed product, so no signed types are needed.
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, div_b, uq, ur, sq, sr, dq, dr;
  logic        a_neg, b_neg;

  always_comb begin
    prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u = {32'd0, src_a} * {32'd0, src_b};
    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 without any overflow special case.
    a_neg  = src_a[31];
    b_neg  = src_b[31];
    abs_a  = a_neg ? (~src_a + 32'd1) : src_a;
    abs_b  = b_neg ? (~src_b + 32'd1) : src_b;
    // Divisor of zero is replaced so the divider never sees it; the result
    // is discarded in that case anyway.
    div_b  = (abs_b == 32'd0) ? 32'd1 : abs_b;
    sq     = abs_a / div_b;
    sr     = abs_a % div_b;
    uq     = src_a / ((src_b == 32'd0) ? 32'd1 : src_b);
    ur     = src_a % ((src_b == 32'd0) ? 32'd1 : src_b);
    dq     = (a_neg ^ b_neg) ? (~sq + 32'd1) : sq;
    dr     = a_neg ? (~sr + 32'd1) : sr;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            OP_MULT, OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = (md_op == OP_MULT) ? prod_s : prod_u;
              cnt_d   = MULT_CNT;
              state_d = BUSY;
            end
            OP_DIV, OP_DIVU: begin
              if (src_b == 32'd0) begin
                // Divide by zero: run the full period, commit old HI/LO.
                pend_hi_d = hi_q;
                pend_lo_d = lo_q;
              end else if (md_op == OP_DIV) begin
                pend_hi_d = dr;
                pend_lo_d = dq;
              end else begin
                pend_hi_d = ur;
                pend_lo_d = uq;
              end
              cnt_d   = DIV_CNT;
              state_d = BUSY;
            end
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt_q == 8'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy  = (state_q == BUSY);
  // md_op[2]==0 selects MULT/MULTU/DIV/DIVU.
  assign stall = d_md_use & (busy | (start & ~md_op[2]));
  assign hi    = hi_q;
  assign lo    = lo_q;
endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed scenarios plus randomized
// ops checked against a 64-bit arithmetic reference model.
module tb_md_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        d_md_use;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .d_md_use(d_md_use),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {hi,lo} after op commits, from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] h,
                                         input logic [31:0] l);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin q = sa * sb; return q; end
      3'd1: begin p = ua * ub; return p; end
      3'd2: begin
        if (b == 0) return {h, l};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {h, l};
        p = ua / ub; ua = ua % ub;
        return {ua[31:0], p[31:0]};
      end
      3'd4: return {a, l};
      3'd5: return {h, a};
      default: return {h, l};
    endcase
  endfunction

  function automatic int ref_cycles(input logic [2:0] op);
    if (op < 3'd2) return 5;
    if (op < 3'd4) return 10;
    return 0;
  endfunction

  // Issue one op in the current cycle, then step until busy drops (bounded).
  // Returns busy cycle count and whether hi/lo held still while busy.
  task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nb, output bit stable);
    logic [31:0] h0, l0;
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    step();
    start = 1'b0;
    h0 = hi; l0 = lo;
    nb = 0; stable = 1'b1;
    while (busy && nb < 300) begin
      nb++;
      if (hi !== h0 || lo !== l0) stable = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; md_op = 3'd0; src_a = 0; src_b = 0; d_md_use = 1'b1;
    #3;
    n_checks++;
    if ({busy, stall, hi, lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b stall=%b hi=%h lo=%h, want all 0", busy, stall, hi, lo);
    end
    #14 reset_n = 1'b1;
    d_md_use = 1'b0;
    step();
  endtask

  task automatic test_mult();
    bit ok;
    start = 1'b1; md_op = 3'd0; src_a = 32'hFFFFFFFD; src_b = 32'd5;
    step();
    start = 1'b0;
    ok = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      if (busy !== 1'b1 || hi !== 0 || lo !== 0) ok = 1'b0;
      step();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mult_busy: busy/hi/lo wrong in cycles 1..5 (last busy=%b hi=%h lo=%h)", busy, hi, lo);
    end
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      n_fail++;
      $display("FAIL mult_result: busy=%b hi=%h lo=%h, want 0 ffffffff fffffff1", busy, hi, lo);
    end
  endtask

  task automatic test_multu();
    int nb; bit st;
    do_md(3'd1, 32'hFFFFFFFD, 32'd5, nb, st);
    n_checks++;
    if (nb != 5 || !st || hi !== 32'h4 || lo !== 32'hFFFFFFF1) begin
      n_fail++;
      $display("FAIL multu: busy_cycles=%0d stable=%b hi=%h lo=%h, want 5 1 00000004 fffffff1", nb, st, hi, lo);
    end
  endtask

  task automatic test_div();
    int nb; bit st;
    do_md(3'd2, 32'hFFFFFFF9, 32'd2, nb, st);
    n_checks++;
    if (nb != 10 || !st || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      n_fail++;
      $display("FAIL div: busy_cycles=%0d stable=%b hi=%h lo=%h, want 10 1 ffffffff fffffffd", nb, st, hi, lo);
    end
    do_md(3'd3, 32'd7, 32'd2, nb, st);
    n_checks++;
    if (nb != 10 || hi !== 32'd1 || lo !== 32'd3) begin
      n_fail++;
      $display("FAIL divu: busy_cycles=%0d hi=%h lo=%h, want 10 1 3", nb, hi, lo);
    end
    do_md(3'd2, 32'h80000000, 32'hFFFFFFFF, nb, st);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'h80000000) begin
      n_fail++;
      $display("FAIL div_ovf: hi=%h lo=%h, want 0 80000000", hi, lo);
    end
  endtask

  task automatic test_stall_ignore();
    bit ok;
    d_md_use = 1'b1;
    start = 1'b1; md_op = 3'd2; src_a = 32'd100; src_b = 32'd7;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_c0: stall=%b, want 1", stall);
    end
    step();
    start = 1'b0;
    ok = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 3) begin start = 1'b1; md_op = 3'd4; src_a = 32'h1234; end
      else start = 1'b0;
      #1;
      if (stall !== 1'b1 || busy !== 1'b1) ok = 1'b0;
      step();
    end
    start = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_busy: stall/busy dropped during cycles 1..10, want 1");
    end
    n_checks++;
    if (stall !== 1'b0 || busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
      n_fail++;
      $display("FAIL stall_c11: stall=%b busy=%b hi=%h lo=%h, want 0 0 2 e", stall, busy, hi, lo);
    end
    start = 1'b1; md_op = 3'd4; src_a = 32'h1234;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi_stall: stall=%b, want 0", stall);
    end
    step();
    start = 1'b0;
    n_checks++;
    if (hi !== 32'h1234 || lo !== 32'd14 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi_c12: hi=%h lo=%h busy=%b, want 1234 e 0", hi, lo, busy);
    end
    d_md_use = 1'b0;
  endtask

  task automatic test_div_zero();
    int nb; bit st;
    do_md(3'd4, 32'hAAAA, 32'd0, nb, st);
    do_md(3'd5, 32'h5555, 32'd0, nb, st);
    do_md(3'd2, 32'd77, 32'd0, nb, st);
    n_checks++;
    if (nb != 10 || hi !== 32'hAAAA || lo !== 32'h5555) begin
      n_fail++;
      $display("FAIL div_zero: busy_cycles=%0d hi=%h lo=%h, want 10 aaaa 5555", nb, hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    start = 1'b1; md_op = 3'd0; src_a = 32'd3; src_b = 32'd4;
    step();
    start = 1'b0;
    step(); step();
    #2 reset_n = 1'b0; d_md_use = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || stall !== 1'b0 || hi !== 0 || lo !== 0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b stall=%b hi=%h lo=%h, want all 0", busy, stall, hi, lo);
    end
    #8 reset_n = 1'b1;
    d_md_use = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (busy !== 1'b0 || hi !== 0 || lo !== 0) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_nocommit: busy=%b hi=%h lo=%h, want 0 0 0", busy, hi, lo);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    int nb; bit st;
    eh = hi; el = lo;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 9));
        3: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      {eh, el} = ref_md(op, a, b, eh, el);
      do_md(op, a, b, nb, st);
      n_checks++;
      if (nb != ref_cycles(op) || !st || hi !== eh || lo !== el) begin
        n_fail++;
        $display("FAIL rand%0d op=%0d a=%h b=%h: cycles=%0d stable=%b hi=%h lo=%h, want %0d 1 %h %h",
                 i, op, a, b, nb, st, hi, lo, ref_cycles(op), eh, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_stall_ignore();
    test_div_zero();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decoded E-stage instruction and owns the HI/LO registers.
- Models unit latency with a busy counter and raises the D-stage stall request when a HI/LO-related instruction must wait.
- Feeds the hazard unit (stall) and the MFHI/MFLO read path (hi, lo).

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU; legal range 1..255.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..255.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  the E-stage instruction is an md op; qualifies md_op.
- md_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are reserved.
- src_a  input  32  forwarded rs value.
- src_b  input  32  forwarded rt value.
- d_md_use  input  1  the D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- busy  output  1  an operation is in flight.
- stall  output  1  stall request to the hazard unit (freeze PC and F/D, bubble into E).
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset_n low, asynchronous) forces:
  - state IDLE, counter 0, busy 0;
  - hi and lo to 0;
  - pending result registers to 0;
  - any in-flight operation is discarded with no commit.
- States are IDLE and BUSY, with an 8-bit down-counter.
- Accept: an op is accepted only when state is IDLE, start=1 and md_op is legal.
  - start in BUSY is ignored and has no effect on state, hi, lo or the counter.
  - Reserved md_op values are ignored.
- MTHI/MTLO at accept: hi (or lo) <= src_a at the same edge; no BUSY entry; busy stays 0.
- MULT/MULTU/DIV/DIVU at accept:
  - the result is computed from src_a/src_b at that edge and latched into pend_hi/pend_lo;
  - counter <= MULT_CYCLES or DIV_CYCLES; state <= BUSY.
- BUSY:
  - busy=1 and the counter decrements every cycle.
  - When counter==1 at an edge: hi <= pend_hi, lo <= pend_lo, state <= IDLE, counter <= 0.
- Timing: with accept at the edge ending cycle 0, busy is high for cycles 1..N and new hi/lo are visible from cycle N+1.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi = product[63:32], lo = product[31:0].
  - MULTU: the same, unsigned.
  - DIV: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned.
  - src_b == 0 on DIV/DIVU: full DIV_CYCLES busy period runs, but pend registers load the current hi/lo, so hi/lo are unchanged at commit.
  - DIV with 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- stall = d_md_use & (busy | (start & md_op is MULT/MULTU/DIV/DIVU)). This is combinational.
  - On the final busy cycle, stall is still 1; the D instruction is released the following cycle.
- hi and lo are register outputs and never change while busy=1.
- With back-to-back md ops under correct stalling, the second op is accepted in the first cycle with busy=0.

Test Plan:
- MULT:
  - Stimulus: reset, then start with md_op=000, src_a=0xFFFFFFFD, src_b=5.
  - Required: busy=1 in cycles 1..5; hi=0xFFFFFFFF, lo=0xFFFFFFF1 from cycle 6; hi/lo=0 before that.
- MULTU:
  - Stimulus: same operands with md_op=001.
  - Required: hi=0x00000004, lo=0xFFFFFFF1 after 5 busy cycles.
- DIV and DIVU:
  - Stimulus: DIV with src_a=0xFFFFFFF9 (-7), src_b=2.
  - Required: busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Stimulus: DIVU with 7/2.
  - Required: lo=3, hi=1.
- Stall and ignored start:
  - Stimulus: DIV accepted, d_md_use=1 held, and start with MTHI src_a=0x1234 pulsed in cycle 3.
  - Required: stall=1 in cycle 0 and cycles 1..10, stall=0 in cycle 11; MTHI ignored; an MTHI issued in cycle 11 gives hi=0x1234 from cycle 12, busy stays 0.
- Divide by zero:
  - Stimulus: preload hi=0xAAAA, lo=0x5555 via MTHI/MTLO, then DIV with src_b=0.
  - Required: busy for 10 cycles; hi=0xAAAA, lo=0x5555 unchanged.
- Reset mid-operation:
  - Stimulus: reset_n low asynchronously in cycle 3 of a MULT.
  - Required: busy=0, stall=0 (with start=0), hi=lo=0 immediately; no commit after reset_n rises.
